// File: rtl/c_fetch_realign_buffer.sv
// c_fetch_realign_buffer
// Circular halfword buffer between instruction fetch and decode. Fetch words
// are split into 16-bit halfwords; the head of the buffer is decoded as either
// a compressed (16-bit) or a full (32-bit) instruction. 32-bit instructions
// may straddle two fetch words. A misaligned start PC is handled by dropping
// the leading halfwords of the first fetch word after reset or redirect.
module c_fetch_realign_buffer #(
  parameter int          FETCH_W  = 32,
  parameter int          BUF_HW   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      redirect_i,
  input  logic [31:0]               redirect_pc_i,
  input  logic                      fetch_valid_i,
  output logic                      fetch_ready_o,
  input  logic [FETCH_W-1:0]        fetch_data_i,
  output logic                      instr_valid_o,
  input  logic                      instr_ready_i,
  output logic [31:0]               instr_o,
  output logic [31:0]               instr_pc_o,
  output logic                      is_compressed_o,
  output logic [$clog2(BUF_HW):0]   occupancy_o
);

  localparam int HW_PER = FETCH_W / 16;
  localparam int SKIP_W = $clog2(HW_PER);
  localparam int PTR_W  = $clog2(BUF_HW);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [CNT_W:0]   BUF_HW_C = (CNT_W+1)'(BUF_HW);
  localparam logic [CNT_W:0]   HW_PER_C = (CNT_W+1)'(HW_PER);
  localparam logic [CNT_W-1:0] HW_PER_N = CNT_W'(HW_PER);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Halfword storage: data only, never reset
  logic [15:0]       hw_buf [BUF_HW];

  // Control state
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       head_pc_q;
  logic              skip_pend_q;
  logic [SKIP_W-1:0] skip_n_q;

  // Combinational decode and handshake signals
  logic [15:0]       hw0;
  logic [15:0]       hw1;
  logic              comp;
  logic [CNT_W-1:0]  need_n;
  logic [CNT_W:0]    room;
  logic              ready_raw;
  logic              push;
  logic              pop;
  logic [SKIP_W-1:0] skip_eff;
  logic [CNT_W-1:0]  pushed;
  logic [CNT_W-1:0]  push_n;
  logic [CNT_W-1:0]  pop_n;

  // Head decode, acceptance and handshake qualification
  always_comb begin
    hw0       = hw_buf[rd_ptr_q];
    hw1       = hw_buf[rd_ptr_q + PTR_ONE];
    comp      = (hw0[1:0] != 2'b11);
    need_n    = comp ? CNT_W'(1) : CNT_W'(2);

    // Room is judged on the registered count only, so a pop in the same
    // cycle never opens the gate early.
    room      = BUF_HW_C - {1'b0, cnt_q};
    ready_raw = !redirect_i && (room >= HW_PER_C);

    fetch_ready_o   = reset || ready_raw;
    instr_valid_o   = !reset && !redirect_i && (cnt_q >= need_n);
    is_compressed_o = !reset && comp;
    instr_o         = 32'h0;
    if (!reset) begin
      instr_o = comp ? {16'h0, hw0} : {hw1, hw0};
    end
    instr_pc_o  = head_pc_q;
    occupancy_o = cnt_q;

    push = fetch_valid_i && ready_raw;
    pop  = instr_valid_o && instr_ready_i;

    // Leading halfwords below the start PC are dropped from the first word
    skip_eff = skip_pend_q ? skip_n_q : '0;
    pushed   = HW_PER_N - CNT_W'(skip_eff);
    push_n   = push ? pushed : '0;
    pop_n    = pop ? need_n : '0;
  end

  // Write accepted halfwords behind the current tail; the head is never touched
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < HW_PER; i++) begin
        if (i >= int'(skip_eff)) begin
          hw_buf[wr_ptr_q + PTR_W'(i - int'(skip_eff))] <= fetch_data_i[16*i +: 16];
        end
      end
    end
  end

  // Pointer, count, PC and skip bookkeeping; redirect flushes everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      head_pc_q   <= RESET_PC;
      skip_pend_q <= 1'b1;
      skip_n_q    <= RESET_PC[SKIP_W:1];
    end else if (redirect_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      head_pc_q   <= redirect_pc_i & ~32'h1;
      skip_pend_q <= 1'b1;
      skip_n_q    <= redirect_pc_i[SKIP_W:1];
    end else begin
      if (push) begin
        wr_ptr_q    <= wr_ptr_q + pushed[PTR_W-1:0];
        skip_pend_q <= 1'b0;
      end
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + need_n[PTR_W-1:0];
        head_pc_q <= head_pc_q + (32'(need_n) << 1);
      end
      cnt_q <= cnt_q + push_n - pop_n;
    end
  end

endmodule

// File: tb/tb_c_fetch_realign_buffer.sv
// Bench for c_fetch_realign_buffer (FETCH_W=32, BUF_HW=8, RESET_PC=0).
// A halfword-stream model turns accepted fetch words into an expected
// instruction queue; a negedge monitor compares the DUT head against it.
module tb_c_fetch_realign_buffer;
  localparam int BH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_data_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        is_compressed_o;
  logic [3:0]  occupancy_o;

  c_fetch_realign_buffer #(.FETCH_W(32), .BUF_HW(BH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o), .fetch_data_i(fetch_data_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_o(instr_o),
    .instr_pc_o(instr_pc_o), .is_compressed_o(is_compressed_o), .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act !== req) begin
      bad_cnt++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, req, $time);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        comp;
    int          sz;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] hq[$];
  logic [31:0] hq_pc;
  int          m_total;
  bit          m_skip;
  int          m_skip_n;
  int          pend_pop;
  bit          m_push_acc;

  // Reference model: halfword stream -> instruction list
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete(); hq.delete();
      hq_pc = 32'h0; m_total = 0; m_skip = 1'b1; m_skip_n = 0;
      pend_pop = 0; m_push_acc = 1'b0;
    end else if (redirect_i) begin
      exp_q.delete(); hq.delete();
      hq_pc = {redirect_pc_i[31:1], 1'b0};
      m_total = 0; m_skip = 1'b1; m_skip_n = int'(redirect_pc_i[1]);
      pend_pop = 0; m_push_acc = 1'b0;
    end else begin
      m_push_acc = fetch_valid_i && (BH - m_total >= 2);
      m_total -= pend_pop;
      pend_pop = 0;
      if (m_push_acc) begin
        for (int i = (m_skip ? m_skip_n : 0); i < 2; i++) begin
          hq.push_back(fetch_data_i[16*i +: 16]);
          m_total++;
        end
        m_skip = 1'b0;
        while (hq.size() > 0) begin
          exp_t e;
          if (hq[0][1:0] != 2'b11) begin
            e.instr = {16'h0, hq[0]}; e.pc = hq_pc; e.comp = 1'b1; e.sz = 1;
            exp_q.push_back(e);
            void'(hq.pop_front());
            hq_pc += 2;
          end else if (hq.size() >= 2) begin
            e.instr = {hq[1], hq[0]}; e.pc = hq_pc; e.comp = 1'b0; e.sz = 2;
            exp_q.push_back(e);
            void'(hq.pop_front());
            void'(hq.pop_front());
            hq_pc += 4;
          end else begin
            break;
          end
        end
      end
    end
  end

  // Monitor: compare head against the scoreboard; pop on handshake
  always @(negedge clk) begin
    bit   ev;
    exp_t e;
    if (!reset) begin
      ev = !redirect_i && (exp_q.size() > 0);
      check("occupancy", 32'(occupancy_o), 32'(m_total));
      check("fetch_ready", 32'(fetch_ready_o), 32'(!redirect_i && (BH - m_total >= 2)));
      check("instr_valid", 32'(instr_valid_o), 32'(ev));
      if (ev) begin
        e = exp_q[0];
        check("instr", instr_o, e.instr);
        check("instr_pc", instr_pc_o, e.pc);
        check("is_compressed", 32'(is_compressed_o), 32'(e.comp));
        if (instr_ready_i) begin
          pend_pop = e.sz;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic push_word(input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    fetch_valid_i = 1'b1;
    fetch_data_i  = d;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (m_push_acc) begin
        ok = 1'b1;
        break;
      end
    end
    fetch_valid_i = 1'b0;
    if (!ok) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    fetch_valid_i = 1'b0;
    @(posedge clk); #1;
    redirect_i = 1'b0;
  endtask

  task automatic head_is(input string name, input logic [31:0] ins, input logic [31:0] pc, input logic c);
    check({name, "_valid"}, 32'(instr_valid_o), 32'd1);
    check({name, "_instr"}, instr_o, ins);
    check({name, "_pc"}, instr_pc_o, pc);
    check({name, "_comp"}, 32'(is_compressed_o), 32'(c));
  endtask

  logic [31:0] mem [256];
  logic [31:0] fa;
  logic [31:0] rpc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    fetch_valid_i = 1'b0; fetch_data_i = 32'h0; instr_ready_i = 1'b0;
    #1;
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_ready", 32'(fetch_ready_o), 32'd1);
    check("rst_occ", 32'(occupancy_o), 32'd0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc", instr_pc_o, 32'h0);
    check("rst_comp", 32'(is_compressed_o), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Aligned 32-bit instruction
    instr_ready_i = 1'b1;
    push_word(32'h0000_0013);
    head_is("t1", 32'h0000_0013, 32'h0, 1'b0);
    @(posedge clk); #1;
    check("t1_occ", 32'(occupancy_o), 32'd0);

    // Two compressed instructions in one word
    do_redirect(32'h0);
    push_word(32'h4501_4501);
    head_is("t2a", 32'h0000_4501, 32'h0, 1'b1);
    @(posedge clk); #1;
    head_is("t2b", 32'h0000_4501, 32'h2, 1'b1);
    @(posedge clk); #1;
    check("t2_empty", 32'(instr_valid_o), 32'd0);

    // Straddling 32-bit instruction
    do_redirect(32'h0);
    push_word(32'h0013_4501);
    head_is("t3a", 32'h0000_4501, 32'h0, 1'b1);
    @(posedge clk); #1;
    check("t3_wait_valid", 32'(instr_valid_o), 32'd0);
    check("t3_wait_occ", 32'(occupancy_o), 32'd1);
    @(posedge clk); #1;
    check("t3_wait_valid2", 32'(instr_valid_o), 32'd0);
    push_word(32'h4501_0000);
    head_is("t3b", 32'h0000_0013, 32'h2, 1'b0);
    @(posedge clk); #1;
    head_is("t3c", 32'h0000_4501, 32'h6, 1'b1);
    @(posedge clk); #1;

    // Redirect with data buffered, misaligned target
    do_redirect(32'h0);
    push_word(32'h0013_4501);
    @(posedge clk); #1;
    instr_ready_i = 1'b0;
    push_word(32'h4501_0000);
    check("t4_occ3", 32'(occupancy_o), 32'd3);
    do_redirect(32'h102);
    check("t4_flush_occ", 32'(occupancy_o), 32'd0);
    check("t4_flush_valid", 32'(instr_valid_o), 32'd0);
    instr_ready_i = 1'b1;
    push_word(32'hABCD_4501);
    head_is("t4", 32'h0000_ABCD, 32'h102, 1'b1);
    @(posedge clk); #1;
    check("t4_empty", 32'(occupancy_o), 32'd0);

    // Fill to capacity under backpressure, then drain
    instr_ready_i = 1'b0;
    do_redirect(32'h0);
    for (int i = 0; i < 4; i++) push_word(32'h4501_4501);
    repeat (3) @(posedge clk);
    #1;
    check("t5_full_occ", 32'(occupancy_o), 32'd8);
    check("t5_full_ready", 32'(fetch_ready_o), 32'd0);
    head_is("t5_frozen", 32'h0000_4501, 32'h0, 1'b1);
    instr_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      head_is("t5_drain", 32'h0000_4501, 32'(2 * i), 1'b1);
      @(posedge clk); #1;
    end
    check("t5_drained", 32'(instr_valid_o), 32'd0);

    // Asynchronous reset mid-drain
    instr_ready_i = 1'b0;
    do_redirect(32'h0);
    for (int i = 0; i < 3; i++) push_word(32'h4501_4501);
    instr_ready_i = 1'b1;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("t6_rst_valid", 32'(instr_valid_o), 32'd0);
    check("t6_rst_occ", 32'(occupancy_o), 32'd0);
    check("t6_rst_pc", instr_pc_o, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    push_word(32'h0000_0013);
    head_is("t6_after", 32'h0000_0013, 32'h0, 1'b0);
    @(posedge clk); #1;

    // Randomized stream with backpressure and occasional redirects
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    rpc = {22'h0, 9'($urandom_range(0, 511)), 1'b0};
    do_redirect(rpc);
    fa = rpc & ~32'h3;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 99) == 0) begin
        rpc = {22'h0, 9'($urandom_range(0, 511)), 1'b0};
        instr_ready_i = 1'($urandom_range(0, 1));
        do_redirect(rpc);
        fa = rpc & ~32'h3;
      end else begin
        fetch_valid_i = ($urandom_range(0, 3) != 0);
        fetch_data_i  = mem[fa[9:2]];
        instr_ready_i = ($urandom_range(0, 2) != 0);
        @(posedge clk); #1;
        if (m_push_acc) fa = fa + 32'd4;
      end
    end
    fetch_valid_i = 1'b0;
    instr_ready_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("final_valid", 32'(instr_valid_o), 32'(exp_q.size() > 0));

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
